// File: rtl/argmax_scan_unit.sv
// Sequential argmax over a packed vector of signed activations, LANES entries per cycle.
// Returns winner index/value, runner-up value, margin and a low-confidence flag.
module argmax_scan_unit #(
    parameter int unsigned NEURONS    = 10,
    parameter int unsigned RES        = 8,
    parameter int unsigned LANES      = 1,
    parameter int unsigned TIE_LOWEST = 1,
    parameter int unsigned IDX_W      = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [RES*NEURONS-1:0]   output_activations,
    input  logic [RES:0]             conf_threshold,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [IDX_W-1:0]         predicted_digit,
    output logic [RES-1:0]           max_value,
    output logic [RES-1:0]           second_value,
    output logic [RES:0]             margin,
    output logic                     low_conf
);

    localparam int unsigned SEL_W = $clog2(NEURONS);
    localparam int unsigned PTR_W = $clog2(NEURONS + LANES) + 1;
    localparam logic signed [RES-1:0] MOST_NEG = {1'b1, {(RES-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, SCAN, HOLD} state_t;

    state_t                  state;
    logic signed [RES-1:0]   act   [NEURONS];
    logic signed [RES-1:0]   vec_r [NEURONS];
    logic [RES:0]            thr_r;
    logic [PTR_W-1:0]        ptr_r;
    logic signed [RES-1:0]   max_r;
    logic signed [RES-1:0]   sec_r;
    logic [IDX_W-1:0]        idx_r;

    logic signed [RES-1:0]   scan_max_c;
    logic signed [RES-1:0]   scan_sec_c;
    logic [IDX_W-1:0]        scan_idx_c;
    logic                    scan_last_c;
    logic signed [RES-1:0]   lane_v_c;
    int unsigned             lane_e_c;
    logic                    beats_c;
    logic [RES:0]            margin_c;

    // Unpack the flat activation bus into addressable entries
    for (genvar g = 0; g < NEURONS; g++) begin : g_unpack
        assign act[g] = output_activations[g*RES +: RES];
    end

    // One scan step: fold LANES entries into the running max/second in index order
    always_comb begin
        scan_max_c  = max_r;
        scan_sec_c  = sec_r;
        scan_idx_c  = idx_r;
        scan_last_c = 1'b0;
        lane_v_c    = '0;
        lane_e_c    = 0;
        beats_c     = 1'b0;
        for (int unsigned l = 0; l < LANES; l++) begin
            lane_e_c = 32'(ptr_r) + l;
            if (lane_e_c < NEURONS) begin
                lane_v_c = vec_r[SEL_W'(lane_e_c)];
                beats_c  = (TIE_LOWEST != 0) ? (lane_v_c > scan_max_c)
                                             : (lane_v_c >= scan_max_c);
                if (beats_c) begin
                    scan_sec_c = scan_max_c;
                    scan_max_c = lane_v_c;
                    scan_idx_c = IDX_W'(lane_e_c);
                end else if (lane_v_c > scan_sec_c) begin
                    scan_sec_c = lane_v_c;
                end
                if (lane_e_c == NEURONS - 1) begin
                    scan_last_c = 1'b1;
                end
            end
        end
    end

    // Running max never drops below running second, so the difference is non-negative
    assign margin_c = (RES+1)'(max_r) - (RES+1)'(sec_r);

    // Control FSM with registered handshake and result outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state           <= IDLE;
            in_ready        <= 1'b1;
            out_valid       <= 1'b0;
            predicted_digit <= '0;
            max_value       <= '0;
            second_value    <= '0;
            margin          <= '0;
            low_conf        <= 1'b0;
            for (int i = 0; i < NEURONS; i++) begin
                vec_r[i] <= '0;
            end
            thr_r <= '0;
            ptr_r <= '0;
            max_r <= '0;
            sec_r <= '0;
            idx_r <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid && in_ready) begin
                        vec_r    <= act;
                        thr_r    <= conf_threshold;
                        max_r    <= act[0];
                        sec_r    <= MOST_NEG;
                        idx_r    <= '0;
                        ptr_r    <= PTR_W'(1);
                        in_ready <= 1'b0;
                        state    <= SCAN;
                    end
                end
                SCAN: begin
                    max_r <= scan_max_c;
                    sec_r <= scan_sec_c;
                    idx_r <= scan_idx_c;
                    ptr_r <= ptr_r + PTR_W'(LANES);
                    if (scan_last_c) begin
                        state <= HOLD;
                    end
                end
                HOLD: begin
                    if (!out_valid) begin
                        predicted_digit <= idx_r;
                        max_value       <= max_r;
                        second_value    <= sec_r;
                        margin          <= margin_c;
                        low_conf        <= (margin_c < thr_r);
                        out_valid       <= 1'b1;
                    end else if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state     <= IDLE;
                    in_ready  <= 1'b1;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/argmax_scan_unit.md
Name: argmax_scan_unit

Overview:
Sequential, parametrised argmax stage that sits after the output layer of the digit-recognition network. It captures a packed vector of signed output activations on a valid/ready handshake. The vector is scanned LANES entries per cycle, and the unit returns:
- the winning class index and its activation,
- the runner-up activation,
- the winner-minus-runner-up margin,
- a low-confidence flag.

Signed comparison is done correctly, including all-negative vectors. A selectable tie-break rule and backpressure on the result are supported.

Parameters:
NEURONS, 10, number of activations (classes); legal range 2..255.
RES, 8, bit width of each signed activation.
LANES, 1, activations compared per scan cycle; 1..NEURONS.
TIE_LOWEST, 1, 1 = on equal values keep the lower index; 0 = take the higher index.
IDX_W, 8, width of the index output; must be >= clog2(NEURONS).

Ports:
clk  in  1  system clock, rising edge.
rst_n  in  1  asynchronous active-low reset.
in_valid  in  1  activation vector valid.
in_ready  out  1  unit can accept a vector.
output_activations  in  RES*NEURONS  packed signed activations; entry i at bits [i*RES +: RES].
conf_threshold  in  RES+1  unsigned margin threshold; sampled with the vector.
out_valid  out  1  result valid.
out_ready  in  1  downstream accepts result.
predicted_digit  out  IDX_W  index of the maximum activation.
max_value  out  RES  signed maximum activation.
second_value  out  RES  signed second-largest activation (by position, not distinct value).
margin  out  RES+1  unsigned max_value minus second_value.
low_conf  out  1  1 when margin < captured conf_threshold.

Behaviour:
- Reset (async assert, sync deassert expected upstream):
  - state IDLE; in_ready=1; out_valid=0.
  - All result outputs 0; internal vector, threshold and scan counter cleared.
  - Reset mid-scan or mid-output discards the operation; no partial result is ever presented.
- FSM states IDLE, SCAN, HOLD.
- IDLE:
  - in_ready=1.
  - On in_valid&&in_ready: register the full vector and conf_threshold; running max = entry 0, idx = 0, running second = most-negative RES value (-2^(RES-1)); scan pointer = 1; go to SCAN.
- SCAN:
  - in_ready=0.
  - Each cycle process entries pointer..pointer+LANES-1, in ascending index order within the cycle; entries >= NEURONS are ignored.
  - Per entry v:
    - If v beats max: second<=max, max<=v, idx<=entry.
    - Else if v > second (signed): second<=v.
  - "Beats" means strict > when TIE_LOWEST=1, >= when TIE_LOWEST=0. On a tie that does not replace max, v still updates second, so second may equal max.
  - Pointer advances by LANES.
  - After the cycle that processes entry NEURONS-1, go to HOLD.
- Scan cycles: K = ceil((NEURONS-1)/LANES). out_valid rises exactly K+1 clock edges after the accepting edge. Defaults: K=9, out_valid on the 10th edge.
- HOLD:
  - out_valid=1.
  - Outputs are stable and registered: predicted_digit=idx zero-extended, max_value, second_value, margin=max-second computed in RES+1 bits (never negative), low_conf.
  - Held until out_valid&&out_ready. On that edge out_valid<=0 and in_ready<=1 (IDLE).
  - Result outputs keep their last values after handoff. No combinational in_valid->out or out_ready->in_ready path.
  - One vector in flight; new input is accepted only from IDLE, i.e. at earliest the cycle after result handoff.
- Input changes while in_ready=0 have no effect.
- conf_threshold=0 forces low_conf=0. Threshold 2^RES forces low_conf=1 for margins below it.

Test Plan:
1. Defaults; activations idx0..9 = {3,7,-2,100,5,99,0,-128,1,2}, threshold 10 -> after 10 edges: out_valid=1, digit=3, max=100, second=99, margin=1, low_conf=1.
2. All negative {-5,-3,-9,-3,-100,-7,-8,-6,-4,-50}, TIE_LOWEST=1 -> digit=1, max=-3, second=-3, margin=0. Repeat with TIE_LOWEST=0 -> digit=3.
3. Extremes: entry 9 = 127, rest = -128, threshold 0 -> digit=9, margin=255, low_conf=0. Then all entries 127 with TIE_LOWEST=1 -> digit=0, margin=0.
4. Backpressure: out_ready=0 for 20 cycles after out_valid; a second vector is driven with in_valid=1 -> outputs stable, in_ready=0, no capture. Raise out_ready -> handoff, then second vector accepted next cycle and its result correct.
5. LANES=4, NEURONS=10, vector of test 1 -> out_valid 4 edges after acceptance (K=3), same result values.
6. Assert rst_n=0 during scan cycle 5 -> out_valid=0, in_ready=1 immediately. After release, a new vector gives the correct result with no stale data.
